// File: rtl/render_pkg.sv
// render_pkg: screen geometry, colours, FSM state and segment
// encodings shared by the column render sequencer and its calculator.
package render_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [17:0] CEIL_COLOUR  = 18'h0F3CF;
  localparam logic [17:0] FLOOR_COLOUR = 18'h09249;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ_COL,
    ST_WAIT_COL,
    ST_CALC,
    ST_ISSUE,
    ST_WAIT_LINE,
    ST_NEXT_SEG,
    ST_NEXT_COL,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SEG_CEIL,
    SEG_WALL,
    SEG_FLOOR
  } seg_t;

  // One vertical span: inclusive row bounds plus a valid flag.
  typedef struct packed {
    logic       vld;
    logic [6:0] min_y;
    logic [6:0] max_y;
  } span_t;

endpackage

// File: rtl/column_segment_calc.sv
// column_segment_calc: splits one column into ceiling/wall/floor spans.
// in: wall_top, wall_bottom; out: ceil_span, wall_span, floor_span.
module column_segment_calc
  import render_pkg::*;
#(
  parameter int SCREEN_H = render_pkg::SCREEN_H
) (
  input  logic [6:0] wall_top,
  input  logic [6:0] wall_bottom,
  output span_t      ceil_span,
  output span_t      wall_span,
  output span_t      floor_span
);

  localparam logic [7:0] YMAX = 8'(SCREEN_H - 1);

  // 8-bit so b+1 cannot wrap when b is the last row.
  logic [7:0] t;
  logic [7:0] b;
  logic [7:0] t_m1;
  logic [7:0] b_p1;
  logic       empty;

  always_comb begin
    t     = {1'b0, wall_top};
    b     = ({1'b0, wall_bottom} > YMAX) ? YMAX : {1'b0, wall_bottom};
    t_m1  = t - 8'd1;
    b_p1  = b + 8'd1;
    empty = (t > b);

    ceil_span  = '0;
    wall_span  = '0;
    floor_span = '0;

    if (empty) begin
      // Nothing visible: the whole column is ceiling.
      ceil_span.vld   = 1'b1;
      ceil_span.max_y = YMAX[6:0];
    end else begin
      if (t != 8'd0) begin
        ceil_span.vld   = 1'b1;
        ceil_span.max_y = t_m1[6:0];
      end
      wall_span.vld   = 1'b1;
      wall_span.min_y = t[6:0];
      wall_span.max_y = b[6:0];
      if (b < YMAX) begin
        floor_span.vld   = 1'b1;
        floor_span.min_y = b_p1[6:0];
        floor_span.max_y = YMAX[6:0];
      end
    end
  end

endmodule

// File: rtl/column_render_sequencer.sv
// column_render_sequencer: per frame walks columns, fetches a wall span
// per column and issues ceiling/wall/floor line commands with start/done.
// in: clock, reset, frame_start, col_valid, wall_*, line_done
// out: busy, frame_done, col_req, col_x, line_start, line_*
module column_render_sequencer
  import render_pkg::*;
#(
  parameter int          SCREEN_W     = render_pkg::SCREEN_W,
  parameter int          SCREEN_H     = render_pkg::SCREEN_H,
  parameter logic [17:0] CEIL_COLOUR  = render_pkg::CEIL_COLOUR,
  parameter logic [17:0] FLOOR_COLOUR = render_pkg::FLOOR_COLOUR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic        col_req,
  output logic [7:0]  col_x,
  input  logic        col_valid,
  input  logic [6:0]  wall_top,
  input  logic [6:0]  wall_bottom,
  input  logic [17:0] wall_colour,
  output logic        line_start,
  output logic [7:0]  line_x,
  output logic [6:0]  line_min_y,
  output logic [6:0]  line_max_y,
  output logic [17:0] line_colour,
  input  logic        line_done
);

  localparam logic [7:0] LAST_COL = 8'(SCREEN_W - 1);

  state_t      state_q, state_d;
  seg_t        seg_q, seg_d;
  logic [7:0]  col_x_q, col_x_d;
  logic [6:0]  top_q, top_d;
  logic [6:0]  bot_q, bot_d;
  logic [17:0] wcol_q, wcol_d;
  logic [7:0]  lx_q, lx_d;
  logic [6:0]  lmin_q, lmin_d;
  logic [6:0]  lmax_q, lmax_d;
  logic [17:0] lcol_q, lcol_d;

  span_t       ceil_span;
  span_t       wall_span;
  span_t       floor_span;

  logic        has_next;
  seg_t        next_seg;
  span_t       next_span;
  logic [17:0] next_colour;

  column_segment_calc #(
    .SCREEN_H (SCREEN_H)
  ) u_calc (
    .wall_top    (top_q),
    .wall_bottom (bot_q),
    .ceil_span   (ceil_span),
    .wall_span   (wall_span),
    .floor_span  (floor_span)
  );

  // Next non-empty segment in CEIL, WALL, FLOOR order. In CALC the
  // first one is picked; otherwise the one following seg_q.
  always_comb begin
    has_next = 1'b0;
    next_seg = SEG_CEIL;
    if (state_q == ST_CALC) begin
      has_next = 1'b1;
      next_seg = ceil_span.vld ? SEG_CEIL : SEG_WALL;
    end else begin
      case (seg_q)
        SEG_CEIL: begin
          if (wall_span.vld) begin
            has_next = 1'b1;
            next_seg = SEG_WALL;
          end else if (floor_span.vld) begin
            has_next = 1'b1;
            next_seg = SEG_FLOOR;
          end
        end
        SEG_WALL: begin
          if (floor_span.vld) begin
            has_next = 1'b1;
            next_seg = SEG_FLOOR;
          end
        end
        default: ;
      endcase
    end

    next_span   = floor_span;
    next_colour = FLOOR_COLOUR;
    case (next_seg)
      SEG_CEIL: begin
        next_span   = ceil_span;
        next_colour = CEIL_COLOUR;
      end
      SEG_WALL: begin
        next_span   = wall_span;
        next_colour = wcol_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    col_x_d = col_x_q;
    top_d   = top_q;
    bot_d   = bot_q;
    wcol_d  = wcol_q;
    lx_d    = lx_q;
    lmin_d  = lmin_q;
    lmax_d  = lmax_q;
    lcol_d  = lcol_q;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_REQ_COL;
          col_x_d = 8'd0;
        end
      end
      ST_REQ_COL, ST_WAIT_COL: begin
        // col_req is high in both, so a valid in either is taken.
        if (col_valid) begin
          top_d   = wall_top;
          bot_d   = wall_bottom;
          wcol_d  = wall_colour;
          state_d = ST_CALC;
        end else begin
          state_d = ST_WAIT_COL;
        end
      end
      ST_CALC, ST_NEXT_SEG: begin
        if (has_next) begin
          seg_d   = next_seg;
          lx_d    = col_x_q;
          lmin_d  = next_span.min_y;
          lmax_d  = next_span.max_y;
          lcol_d  = next_colour;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_NEXT_COL;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_LINE;
      end
      ST_WAIT_LINE: begin
        if (line_done) state_d = ST_NEXT_SEG;
      end
      ST_NEXT_COL: begin
        if (col_x_q == LAST_COL) begin
          state_d = ST_DONE;
        end else begin
          col_x_d = col_x_q + 8'd1;
          state_d = ST_REQ_COL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      seg_q   <= SEG_CEIL;
      col_x_q <= '0;
      top_q   <= '0;
      bot_q   <= '0;
      wcol_q  <= '0;
      lx_q    <= '0;
      lmin_q  <= '0;
      lmax_q  <= '0;
      lcol_q  <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      col_x_q <= col_x_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      wcol_q  <= wcol_d;
      lx_q    <= lx_d;
      lmin_q  <= lmin_d;
      lmax_q  <= lmax_d;
      lcol_q  <= lcol_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = (state_q == ST_DONE);
  assign col_req     = (state_q == ST_REQ_COL) ||
                       (state_q == ST_WAIT_COL);
  assign col_x       = col_x_q;
  assign line_start  = (state_q == ST_ISSUE);
  assign line_x      = lx_q;
  assign line_min_y  = lmin_q;
  assign line_max_y  = lmax_q;
  assign line_colour = lcol_q;

endmodule

// File: tb/tb_column_render_sequencer.sv
// tb_column_render_sequencer: directed bench with raycaster and
// line drawer models around column_render_sequencer.
module tb_column_render_sequencer;

  localparam logic [17:0] CC = 18'h0F3CF;
  localparam logic [17:0] FC = 18'h09249;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        busy;
  logic        frame_done;
  logic        col_req;
  logic [7:0]  col_x;
  logic        col_valid;
  logic [6:0]  wall_top;
  logic [6:0]  wall_bottom;
  logic [17:0] wall_colour;
  logic        line_start;
  logic [7:0]  line_x;
  logic [6:0]  line_min_y;
  logic [6:0]  line_max_y;
  logic [17:0] line_colour;
  logic        line_done;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rst_cnt = 0;
  int stray_cnt = 0;
  int col_delay = 0;
  int ld_fixed = 2;
  bit ld_var = 1'b0;
  int hold_bad = 0;
  int hold_cnt = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;

  logic [6:0]  cfg_top = 7'd40;
  logic [6:0]  cfg_bot = 7'd79;
  logic [17:0] cfg_c = 18'h2AAAA;
  logic [7:0]  o1_x = 8'hFF;
  logic [7:0]  o2_x = 8'hFF;
  logic [6:0]  o1_t = 0, o1_b = 0;
  logic [6:0]  o2_t = 0, o2_b = 0;

  logic [39:0] lines[$];
  logic [39:0] exp_q[$];
  int          st_q[$];
  int          dn_q[$];
  int          vcyc[$];
  logic [7:0]  colq[$];

  column_render_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .busy        (busy),
    .frame_done  (frame_done),
    .col_req     (col_req),
    .col_x       (col_x),
    .col_valid   (col_valid),
    .wall_top    (wall_top),
    .wall_bottom (wall_bottom),
    .wall_colour (wall_colour),
    .line_start  (line_start),
    .line_x      (line_x),
    .line_min_y  (line_min_y),
    .line_max_y  (line_max_y),
    .line_colour (line_colour),
    .line_done   (line_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [39:0] L(input int x, input int lo,
                                     input int hi, input logic [17:0] c);
    return {8'(x), 7'(lo), 7'(hi), c};
  endfunction

  function automatic void push_std(input int x, input logic [17:0] c);
    exp_q.push_back(L(x, 0, 39, CC));
    exp_q.push_back(L(x, 40, 79, c));
    exp_q.push_back(L(x, 80, 119, FC));
  endfunction

  initial begin : fd_mon
    forever begin
      @(posedge clock); #1;
      if (frame_done === 1'b1) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  initial begin : raycaster
    col_valid = 1'b0;
    wall_top = '0;
    wall_bottom = '0;
    wall_colour = '0;
    forever begin
      @(posedge clock); #1;
      col_valid = 1'b0;
      if (col_req === 1'b1) begin
        for (int k = 0; k < col_delay; k++) begin
          @(posedge clock); #1;
        end
        wall_colour = cfg_c;
        if (col_x == o1_x) begin
          wall_top = o1_t;
          wall_bottom = o1_b;
        end else if (col_x == o2_x) begin
          wall_top = o2_t;
          wall_bottom = o2_b;
        end else begin
          wall_top = cfg_top;
          wall_bottom = cfg_bot;
        end
        col_valid = 1'b1;
        colq.push_back(col_x);
        vcyc.push_back(cyc);
      end
    end
  end

  initial begin : drawer
    int n, d, seen, rc0, st;
    logic [39:0] r;
    n = 0;
    seen = 0;
    line_done = 1'b0;
    forever begin
      @(posedge clock); #1;
      line_done = 1'b0;
      if (line_start === 1'b1) begin
        r = {line_x, line_min_y, line_max_y, line_colour};
        st = cyc;
        rc0 = rst_cnt;
        d = ld_var ? (n % 8) : ld_fixed;
        n++;
        for (int k = 0; k <= d; k++) begin
          @(posedge clock); #1;
          if (rst_cnt == rc0) begin
            hold_cnt++;
            if ({line_start, line_x, line_min_y, line_max_y, line_colour}
                !== {1'b0, r})
              hold_bad++;
          end
        end
        line_done = 1'b1;
        if (rst_cnt == rc0) begin
          lines.push_back(r);
          st_q.push_back(st);
          dn_q.push_back(cyc);
        end
      end else if (stray_cnt != seen) begin
        seen = stray_cnt;
        line_done = 1'b1;
      end
    end
  end

  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < 20000) begin
      @(posedge clock); #1;
      k++;
    end
    ok = (frame_done === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    frame_start = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    n_chk++;
    if ({busy, frame_done, col_req, line_start} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 0000",
               {busy, frame_done, col_req, line_start});
    end
    n_chk++;
    if (col_x !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_col_x got %0d exp 0", col_x);
    end
    n_chk++;
    if ({line_x, line_min_y, line_max_y, line_colour} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_line got %h exp 0",
               {line_x, line_min_y, line_max_y, line_colour});
    end
    reset = 1'b0;
    @(posedge clock); #1;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset busy=%b exp 0", busy);
    end
  endtask

  task automatic test_nominal();
    int lb, cb, fb, bad;
    bit ok;
    cfg_top = 40; cfg_bot = 79; cfg_c = 18'h2AAAA;
    col_delay = 0; ld_var = 0; ld_fixed = 2;
    exp_q.delete();
    for (int x = 0; x < 160; x++) push_std(x, cfg_c);
    lb = lines.size(); cb = colq.size(); fb = fd_cnt;
    pulse_start();
    n_chk++;
    if ({busy, col_req, col_x} !== {2'b11, 8'd0}) begin
      n_fail++;
      $display("FAIL start_latency got %b exp 1100000000",
               {busy, col_req, col_x});
    end
    wait_done(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL nominal_done timeout exp frame_done");
    end
    @(posedge clock); #1;
    n_chk++;
    if (fd_cnt - fb !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_fd got %0d busy=%b exp 1 busy=0",
               fd_cnt - fb, busy);
    end
    n_chk++;
    if (lines.size() - lb !== exp_q.size()) begin
      n_fail++;
      $display("FAIL nominal_count got %0d exp %0d",
               lines.size() - lb, exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_chk++;
      if (lb + i >= lines.size() || lines[lb + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL nominal_line[%0d] got %h exp %h",
                 i, lines[lb + i], exp_q[i]);
      end
    end
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (cb + i >= colq.size() || colq[cb + i] !== 8'(i)) bad++;
    n_chk++;
    if (colq.size() - cb !== 160 || bad != 0) begin
      n_fail++;
      $display("FAIL col_seq got n=%0d bad=%0d exp n=160 bad=0",
               colq.size() - cb, bad);
    end
    n_chk++;
    if (fd_cyc - dn_q[$] !== 3) begin
      n_fail++;
      $display("FAIL done_to_fd got %0d exp 3", fd_cyc - dn_q[$]);
    end
    bad = 0;
    for (int i = 1; i < 480; i++)
      if (i % 3 != 0 && st_q[lb + i] - dn_q[lb + i - 1] != 2) bad++;
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL done_to_start got %0d bad exp 0", bad);
    end
    bad = 0;
    for (int x = 0; x < 160; x++)
      if (st_q[lb + 3 * x] - vcyc[cb + x] != 2) bad++;
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL valid_to_start got %0d bad exp 0", bad);
    end
  endtask

  task automatic test_edges();
    int lb;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      exp_q.delete();
      case (k)
        0: begin cfg_top = 0; cfg_bot = 119; cfg_c = 18'h3FFFF; end
        1: begin cfg_top = 0; cfg_bot = 127; cfg_c = 18'h00001; end
        default: begin cfg_top = 119; cfg_bot = 119; cfg_c = 18'h12345; end
      endcase
      for (int x = 0; x < 160; x++) begin
        if (k < 2) begin
          exp_q.push_back(L(x, 0, 119, cfg_c));
        end else begin
          exp_q.push_back(L(x, 0, 118, CC));
          exp_q.push_back(L(x, 119, 119, cfg_c));
        end
      end
      lb = lines.size();
      pulse_start();
      wait_done(ok);
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL edge%0d_done timeout exp frame_done", k);
      end
      @(posedge clock); #1;
      n_chk++;
      if (lines.size() - lb !== exp_q.size()) begin
        n_fail++;
        $display("FAIL edge%0d_count got %0d exp %0d",
                 k, lines.size() - lb, exp_q.size());
      end
      foreach (exp_q[i]) begin
        n_chk++;
        if (lb + i >= lines.size() || lines[lb + i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL edge%0d_line[%0d] got %h exp %h",
                   k, i, lines[lb + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_empty_wall();
    int lb;
    bit ok;
    cfg_top = 40; cfg_bot = 79; cfg_c = 18'h15555;
    o1_x = 8'd5; o1_t = 7'd90; o1_b = 7'd50;
    o2_x = 8'd7; o2_t = 7'd125; o2_b = 7'd126;
    exp_q.delete();
    for (int x = 0; x < 160; x++) begin
      if (x == 5 || x == 7) exp_q.push_back(L(x, 0, 119, CC));
      else push_std(x, cfg_c);
    end
    lb = lines.size();
    pulse_start();
    wait_done(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL empty_done timeout exp frame_done");
    end
    @(posedge clock); #1;
    n_chk++;
    if (lines.size() - lb !== exp_q.size()) begin
      n_fail++;
      $display("FAIL empty_count got %0d exp %0d",
               lines.size() - lb, exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_chk++;
      if (lb + i >= lines.size() || lines[lb + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL empty_line[%0d] got %h exp %h",
                 i, lines[lb + i], exp_q[i]);
      end
    end
    o1_x = 8'hFF;
    o2_x = 8'hFF;
  endtask

  task automatic test_handshakes();
    int lb, cb, fb, hb, hc, bad;
    bit ok;
    cfg_top = 40; cfg_bot = 79; cfg_c = 18'h2AAAA;
    col_delay = 5; ld_var = 1;
    hb = hold_bad; hc = hold_cnt;
    stray_cnt++;
    bad = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if ({busy, line_start, col_req, frame_done} !== 4'b0) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL stray_done got %0d active cycles exp 0", bad);
    end
    exp_q.delete();
    for (int x = 0; x < 160; x++) push_std(x, cfg_c);
    lb = lines.size(); cb = colq.size(); fb = fd_cnt;
    pulse_start();
    repeat (40) begin @(posedge clock); #1; end
    pulse_start();
    wait_done(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL hs_done timeout exp frame_done");
    end
    bad = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (busy !== 1'b0) bad++;
    end
    n_chk++;
    if (fd_cnt - fb !== 1 || bad !== 0) begin
      n_fail++;
      $display("FAIL busy_start_dropped got fd=%0d busy=%0d exp fd=1 busy=0",
               fd_cnt - fb, bad);
    end
    n_chk++;
    if (hold_bad !== hb || hold_cnt - hc < 480) begin
      n_fail++;
      $display("FAIL line_hold got bad=%0d checks=%0d exp bad=0",
               hold_bad - hb, hold_cnt - hc);
    end
    n_chk++;
    if (colq.size() - cb !== 160) begin
      n_fail++;
      $display("FAIL hs_cols got %0d exp 160", colq.size() - cb);
    end
    n_chk++;
    if (lines.size() - lb !== exp_q.size()) begin
      n_fail++;
      $display("FAIL hs_count got %0d exp %0d",
               lines.size() - lb, exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_chk++;
      if (lb + i >= lines.size() || lines[lb + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL hs_line[%0d] got %h exp %h",
                 i, lines[lb + i], exp_q[i]);
      end
    end
    col_delay = 0;
    ld_var = 0;
  endtask

  task automatic test_back_to_back();
    int fb, bad;
    bit ok;
    ld_fixed = 1;
    fb = fd_cnt;
    pulse_start();
    wait_done(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_done1 timeout exp frame_done");
    end
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
    bad = 0;
    if (busy !== 1'b0) bad++;
    @(posedge clock); #1;
    if (busy !== 1'b0) bad++;
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL start_in_done got %0d busy cycles exp 0", bad);
    end
    pulse_start();
    n_chk++;
    if ({busy, col_req, col_x} !== {2'b11, 8'd0}) begin
      n_fail++;
      $display("FAIL b2b_restart got %b exp 1100000000",
               {busy, col_req, col_x});
    end
    wait_done(ok);
    @(posedge clock); #1;
    n_chk++;
    if (!ok || fd_cnt - fb !== 2) begin
      n_fail++;
      $display("FAIL b2b_frames got %0d exp 2", fd_cnt - fb);
    end
    ld_fixed = 2;
  endtask

  task automatic test_reset_mid();
    int lb, cb, k, bad;
    bit ok;
    ld_fixed = 7;
    cfg_top = 40; cfg_bot = 79; cfg_c = 18'h2AAAA;
    pulse_start();
    k = 0;
    while (!(line_start === 1'b1 && line_x == 8'd3) && k < 5000) begin
      @(posedge clock); #1;
      k++;
    end
    n_chk++;
    if (line_start !== 1'b1 || line_x !== 8'd3) begin
      n_fail++;
      $display("FAIL mid_reach got x=%0d exp x=3", line_x);
    end
    @(posedge clock); #1;
    rst_cnt++;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_chk++;
    if ({busy, frame_done, col_req, line_start, col_x,
         line_x, line_min_y, line_max_y, line_colour} !== 52'd0) begin
      n_fail++;
      $display("FAIL mid_reset got %h exp 0",
               {busy, frame_done, col_req, line_start, col_x,
                line_x, line_min_y, line_max_y, line_colour});
    end
    bad = 0;
    repeat (15) begin
      @(posedge clock); #1;
      if ({busy, line_start, col_req} !== 3'b0) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL late_done got %0d active cycles exp 0", bad);
    end
    ld_fixed = 2;
    exp_q.delete();
    for (int x = 0; x < 160; x++) push_std(x, cfg_c);
    lb = lines.size(); cb = colq.size();
    pulse_start();
    n_chk++;
    if ({col_req, col_x} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL restart_col got %b exp 100000000", {col_req, col_x});
    end
    wait_done(ok);
    @(posedge clock); #1;
    n_chk++;
    if (!ok || colq.size() - cb !== 160 || colq[cb] !== 8'd0) begin
      n_fail++;
      $display("FAIL restart_frame got ok=%b cols=%0d exp ok=1 cols=160",
               ok, colq.size() - cb);
    end
    foreach (exp_q[i]) begin
      n_chk++;
      if (lb + i >= lines.size() || lines[lb + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL restart_line[%0d] got %h exp %h",
                 i, lines[lb + i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    test_reset();
    test_nominal();
    test_edges();
    test_empty_wall();
    test_handshakes();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
